// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, schedule sigmas, round-function Sigmas, scheduler state.
// Pure declarations, no logic of its own.
package sha256_pkg;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Rotations written as slice concatenations so each is pure wiring.
    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// SHA-256 round-constant table: K[addr].
// Latency: combinational. Backpressure: none, pure lookup.
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [5:0]  i_addr,
    output logic [31:0] o_data
);

    assign o_data = K[i_addr];

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: 16 words in, W[0..63] out with t and K[t] (K from ROM if SHA256_K_ROM_EN).
// Latency: W[0] valid the cycle after the 16th load handshake, then one word per clock.
// Backpressure: w_ready low freezes the window and all outputs; word_ready is high only while loading.
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        abort,
    input  logic [31:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    output logic [31:0] w_out,
    output logic [31:0] k_out,
    output logic [5:0]  t_out,
    output logic        w_last,
    output logic        w_valid,
    input  logic        w_ready
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_cnt;
    logic [5:0]  w_cnt_nxt;
    logic [31:0] r_win [16];

    logic        w_load_hs;
    logic        w_run_hs;
    logic        w_shift;
    logic [31:0] w_ext;
    logic [31:0] w_append;

    assign w_load_hs = (r_state == ST_LOAD) && word_valid;
    assign w_run_hs  = (r_state == ST_RUN) && w_ready;
    assign w_shift   = (w_load_hs || w_run_hs) && !abort;

    // With win[i] = W[cnt+i], this yields W[cnt+16]; past t = 47 the result is never emitted.
    assign w_ext    = sigma1(r_win[14]) + r_win[9] + sigma0(r_win[1]) + r_win[0];
    assign w_append = (r_state == ST_LOAD) ? word_in : w_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
            r_cnt   <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (abort) begin
            w_state_nxt = ST_LOAD;
            w_cnt_nxt   = 6'd0;
        end else if (w_load_hs) begin
            w_cnt_nxt = r_cnt + 6'd1;
            if (r_cnt == 6'd15) begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = 6'd0;
            end
        end else if (w_run_hs) begin
            // 63 + 1 wraps to 0, which is exactly the count the next load starts from.
            w_cnt_nxt = r_cnt + 6'd1;
            if (r_cnt == 6'd63) begin
                w_state_nxt = ST_LOAD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= 32'd0;
            end
        end else if (w_shift) begin
            for (int i = 0; i < 15; i++) begin
                r_win[i] <= r_win[i+1];
            end
            r_win[15] <= w_append;
        end
    end

    assign word_ready = (r_state == ST_LOAD);
    assign w_valid    = (r_state == ST_RUN);
    assign w_out      = r_win[0];
    assign t_out      = r_cnt;
    assign w_last     = (r_state == ST_RUN) && (r_cnt == 6'd63);

`ifdef SHA256_K_ROM_EN
    sha256_k_rom u_k_rom (
        .i_addr (r_cnt),
        .o_data (k_out)
    );
`else
    assign k_out = 32'd0;
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched: abc block, backpressure, back-to-back, abort, async reset.
module tb_sha256_msg_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] word_in = 32'd0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic [31:0] w_out;
    logic [31:0] k_out;
    logic [5:0]  t_out;
    logic        w_last;
    logic        w_valid;
    logic        w_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] msg     [16];
    logic [31:0] ref_w   [64];
    logic [31:0] obs_w   [64];
    logic [31:0] saved_w [64];

    sha256_msg_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .abort      (abort),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .w_out      (w_out),
        .k_out      (k_out),
        .t_out      (t_out),
        .w_last     (w_last),
        .w_valid    (w_valid),
        .w_ready    (w_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_model();
        for (int t = 0; t < 16; t++) ref_w[t] = msg[t];
        for (int t = 16; t < 64; t++)
            ref_w[t] = s1(ref_w[t-2]) + ref_w[t-7] + s0(ref_w[t-15]) + ref_w[t-16];
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) msg[i] = 32'd0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
    endtask

    task automatic set_pattern(input logic [31:0] seed);
        for (int i = 0; i < 16; i++) msg[i] = (seed * 32'(i + 1)) ^ {16'h5a5a, 16'(i)};
    endtask

    // Loads msg[0..n-1]; an idle cycle follows every gap_every-th word when gap_every != 0.
    task automatic load_words(input int n, input int gap_every);
        int b;
        for (int i = 0; i < n; i++) begin
            b = 0;
            while (word_ready !== 1'b1 && b < 200) begin tick(); b++; end
            if (word_ready !== 1'b1) begin
                checks++; errors++;
                $display("FAIL load word_ready timeout got %b exp 1", word_ready);
            end
            word_in = msg[i];
            word_valid = 1'b1;
            tick();
            word_valid = 1'b0;
            if (gap_every != 0 && (i % gap_every) == gap_every - 1 && i != n - 1) tick();
        end
    endtask

    task automatic check_stream(input string name, input int t0, input int t1);
        int b;
        b = 0;
        while (w_valid !== 1'b1 && b < 40) begin tick(); b++; end
        checks++;
        if (w_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s w_valid timeout got %b exp 1", name, w_valid);
        end
        for (int t = t0; t <= t1; t++) begin
            obs_w[t] = w_out;
            checks++;
            if (w_out !== ref_w[t]) begin
                errors++;
                $display("FAIL %s w_out t=%0d got %h exp %h", name, t, w_out, ref_w[t]);
            end
            checks++;
            if (t_out !== 6'(t)) begin
                errors++;
                $display("FAIL %s t_out got %0d exp %0d", name, t_out, t);
            end
            checks++;
            if (w_last !== ((t == 63) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL %s w_last t=%0d got %b exp %b", name, t, w_last, (t == 63));
            end
            checks++;
            if (w_valid !== 1'b1 || word_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s run flags t=%0d got valid=%b ready=%b exp 1/0", name, t, w_valid, word_ready);
            end
`ifdef SHA256_K_ROM_EN
            if (t == 0) begin
                checks++;
                if (k_out !== 32'h428a2f98) begin
                    errors++;
                    $display("FAIL %s k_out t=0 got %h exp 428a2f98", name, k_out);
                end
            end
            if (t == 63) begin
                checks++;
                if (k_out !== 32'hc67178f2) begin
                    errors++;
                    $display("FAIL %s k_out t=63 got %h exp c67178f2", name, k_out);
                end
            end
`else
            checks++;
            if (k_out !== 32'd0) begin
                errors++;
                $display("FAIL %s k_out t=%0d got %h exp 0", name, t, k_out);
            end
`endif
            tick();
        end
        if (t1 == 63) begin
            checks++;
            if (word_ready !== 1'b1 || w_valid !== 1'b0 || t_out !== 6'd0) begin
                errors++;
                $display("FAIL %s turnaround got ready=%b valid=%b t=%0d exp 1/0/0", name, word_ready, w_valid, t_out);
            end
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (word_ready !== 1'b1 || w_valid !== 1'b0 || w_last !== 1'b0) begin
            errors++;
            $display("FAIL %s flags got ready=%b valid=%b last=%b exp 1/0/0", name, word_ready, w_valid, w_last);
        end
        checks++;
        if (w_out !== 32'd0 || t_out !== 6'd0) begin
            errors++;
            $display("FAIL %s data got w_out=%h t_out=%0d exp 0/0", name, w_out, t_out);
        end
        checks++;
`ifdef SHA256_K_ROM_EN
        if (k_out !== 32'h428a2f98) begin
            errors++;
            $display("FAIL %s k_out got %h exp 428a2f98", name, k_out);
        end
`else
        if (k_out !== 32'd0) begin
            errors++;
            $display("FAIL %s k_out got %h exp 0", name, k_out);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        check_reset_values("reset");
        rst_n = 1'b1;
        tick();
        check_reset_values("reset_released");
    endtask

    task automatic test_abc();
        set_abc();
        build_model();
        w_ready = 1'b1;
        load_words(16, 4);
        check_stream("abc", 0, 63);
        checks++;
        if (obs_w[0] !== 32'h61626380) begin
            errors++; $display("FAIL abc_w0 got %h exp 61626380", obs_w[0]);
        end
        checks++;
        if (obs_w[15] !== 32'h00000018) begin
            errors++; $display("FAIL abc_w15 got %h exp 00000018", obs_w[15]);
        end
        checks++;
        if (obs_w[16] !== 32'h61626380) begin
            errors++; $display("FAIL abc_w16 got %h exp 61626380", obs_w[16]);
        end
        checks++;
        if (obs_w[17] !== 32'h000f0000) begin
            errors++; $display("FAIL abc_w17 got %h exp 000f0000", obs_w[17]);
        end
        for (int t = 0; t < 64; t++) saved_w[t] = obs_w[t];
    endtask

    task automatic test_backpressure();
        set_pattern(32'h9e3779b9);
        build_model();
        w_ready = 1'b1;
        load_words(16, 0);
        check_stream("bp_pre", 0, 19);
        w_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (w_out !== ref_w[20] || t_out !== 6'd20 || w_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got w=%h t=%0d v=%b exp %h/20/1", i, w_out, t_out, w_valid, ref_w[20]);
            end
        end
        w_ready = 1'b1;
        check_stream("bp_post", 20, 63);
    endtask

    task automatic test_back_to_back();
        int e_last;
        int first_hs;
        int b;
        set_abc();
        build_model();
        w_ready = 1'b1;
        load_words(16, 0);
        check_stream("b2b_blk1", 0, 63);
        e_last = cyc;
        set_pattern(32'h3c6ef372);
        build_model();
        load_words(16, 0);
        b = 0;
        while (w_valid !== 1'b1 && b < 40) begin tick(); b++; end
        first_hs = cyc + 1;
        checks++;
        if (first_hs - e_last != 17) begin
            errors++;
            $display("FAIL b2b_latency got %0d cycles exp 17", first_hs - e_last);
        end
        checks++;
        if (w_out !== ref_w[0]) begin
            errors++;
            $display("FAIL b2b_first_word got %h exp %h", w_out, ref_w[0]);
        end
        check_stream("b2b_blk2", 0, 63);
    endtask

    task automatic test_abort();
        set_abc();
        build_model();
        w_ready = 1'b1;
        load_words(16, 0);
        check_stream("abort_pre", 0, 29);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (word_ready !== 1'b1 || w_valid !== 1'b0 || t_out !== 6'd0) begin
            errors++;
            $display("FAIL abort_flush got ready=%b valid=%b t=%0d exp 1/0/0", word_ready, w_valid, t_out);
        end
        load_words(16, 0);
        check_stream("abort_reload", 0, 63);
        for (int t = 0; t < 64; t++) begin
            checks++;
            if (obs_w[t] !== saved_w[t]) begin
                errors++;
                $display("FAIL abort_repeat t=%0d got %h exp %h", t, obs_w[t], saved_w[t]);
            end
        end
    endtask

    task automatic test_async_reset();
        set_pattern(32'hbb67ae85);
        build_model();
        w_ready = 1'b1;
        load_words(7, 0);
        #2;
        checks++;
        if (t_out !== 6'd7) begin
            errors++;
            $display("FAIL arst_preload t_out got %0d exp 7", t_out);
        end
        rst_n = 1'b0;
        #1;
        check_reset_values("arst_immediate");
        tick();
        rst_n = 1'b1;
        tick();
        load_words(16, 0);
        check_stream("arst_reload", 0, 63);
    endtask

    initial begin
        test_reset();
        test_abc();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha256_msg_sched.md
# sha256_msg_sched

SHA-256 message-schedule generator. It sits directly upstream of the combinational round function. It accepts one 512-bit block as 16 big-endian 32-bit words. It then streams the 64 schedule words W[0..63], with round index and round constant, one per handshake, into the round datapath. A 16-entry sliding window produces each extended word in a single cycle, so sustained throughput is one round per clock.

## Interface
- No parameters. Word width is 32 and round count is 64, both fixed by the algorithm.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous and active-low.
- abort  input  1  synchronous flush to LOAD; discards the current block.
- word_in  input  32  message word. The first word accepted is W[0].
- word_valid  input  1  word_in is valid.
- word_ready  output  1  block can accept a word.
- w_out  output  32  schedule word W[t].
- k_out  output  32  round constant K[t]. Tied to 0 when the feature is compiled out.
- t_out  output  6  round index t.
- w_last  output  1  high with w_valid when t = 63.
- w_valid  output  1  w_out, k_out and t_out are valid.
- w_ready  input  1  round stage consumes the current word.

## Operation
- Storage:
  - win[0..15] holds 32-bit words; win[0] is the oldest word.
  - cnt is a 6-bit counter.
  - state is LOAD or RUN.
- LOAD state:
  - word_ready = 1 and w_valid = 0.
  - On each word handshake: win[i] <= win[i+1] for i = 0..14, win[15] <= word_in, cnt <= cnt + 1.
  - On the handshake with cnt = 15: state <= RUN, cnt <= 0.
- RUN state:
  - word_ready = 0 and w_valid = 1.
  - w_out = win[0], t_out = cnt, w_last = (cnt == 63).
  - On each output handshake, the window shifts left and win[15] <= σ1(win[14]) + win[9] + σ0(win[1]) + win[0], with addition mod 2^32. Then cnt <= cnt + 1.
  - Invariant: while in RUN, win[i] = W[cnt+i].
  - Words appended for cnt ≥ 48 are never output; they are don't-care, but the shift still occurs.
  - On the handshake with cnt = 63: state <= LOAD, cnt <= 0.
- Sigma functions:
  - σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- abort:
  - Next state is LOAD with cnt = 0.
  - Window contents are not cleared. They are overwritten by the next 16 loads.
  - abort takes priority over a simultaneous word or w handshake in the same cycle; that handshake is discarded.
- Outputs are registered-state decodes. No combinational path runs from w_ready to w_valid, or from word_valid to word_ready.

## Timing
- Reset values:
  - state = LOAD and cnt = 0; win all 0.
  - word_ready = 1 and w_valid = 0.
  - w_out = 0 and t_out = 0.
  - w_last = 0.
  - k_out = 0x428a2f98 with the feature compiled in, 0 without it.
- Load: 16 cycles minimum, one word per cycle. Gaps in word_valid are allowed.
- Latency: w_valid rises the cycle after the 16th word handshake and carries W[0].
- Output: one word per cycle while w_ready = 1.
- Backpressure: with w_valid = 1 and w_ready = 0, w_out, k_out, t_out and w_last hold stable.
- Turnaround:
  - word_ready rises the cycle after the t = 63 handshake.
  - Minimum block period is 80 cycles: 16 load plus 64 run.
- An asynchronous reset at any point, mid-load or mid-run, returns to the reset values immediately. The partial block is lost.

## Configuration
- SHA256_K_ROM_EN defined:
  - k_out = K[t_out], taken from the 64-entry constant table.
  - Selection is combinational from cnt.
- SHA256_K_ROM_EN undefined:
  - k_out is constant 0, and the ROM is not instantiated.
  - The round stage sources K itself.
- Port list is identical in both builds.

## Structure
- Shared package sha256_pkg holds the K[0..63] constant array, the sigma0/sigma1 functions, and the LOAD/RUN state enum. The round stage reuses the same package, including the upper-case Σ functions placed alongside.
- One sub-module, sha256_k_rom: 6-bit address in, 32-bit constant out. It is instantiated only under SHA256_K_ROM_EN.

## Test plan
- "abc" block: load 0x61626380, then 14 × 0x00000000, then 0x00000018, with w_ready = 1. Required response: W[0] = 0x61626380, W[15] = 0x00000018, W[16] = 0x61626380, W[17] = 0x000f0000. All 64 outputs must match the reference model, and w_last must be high only with t = 63.
- K check, feature compiled in: k_out = 0x428a2f98 at t = 0 and 0xc67178f2 at t = 63. With the feature compiled out, k_out = 0 on every cycle.
- Backpressure: hold w_ready = 0 for 5 cycles at t = 20. w_out and t_out must stay stable at W[20] and 20, and the stream must resume at W[21] with no skipped or duplicated word.
- Back-to-back blocks: start loading a second block the cycle word_ready rises after t = 63. Its first output must come 17 cycles after the last handshake of block 1 and must equal W[0] of block 2.
- Abort: assert abort at t = 30, coincident with a w handshake. The next cycle must show word_ready = 1, w_valid = 0 and t_out = 0. Reloading the "abc" block must reproduce the first scenario's outputs.
- Async reset mid-load: drop rst_n after 7 words. All outputs must take their reset values without a clock edge. After release, a full 16-word load must produce correct W[0..63].
